// File: rtl/mem8_access_sequencer_if.sv
// Request/response and byte-memory bus of the memory-stage load/store sequencer.
// The slave side is the sequencer; the master side is the pipeline plus the byte memory.
interface mem8_access_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid_in;
  logic              req_ready_out;
  logic              req_we_in;
  logic [1:0]        req_size_in;
  logic              req_signed_in;
  logic [ADDR_W-1:0] req_addr_in;
  logic [31:0]       req_wdata_in;
  logic              rsp_valid_out;
  logic [31:0]       rsp_rdata_out;
  logic              busy_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_we_out;
  logic [7:0]        mem_wd_out;
  logic [7:0]        mem_rd_in;

  modport slave (
    input  req_valid_in, req_we_in, req_size_in, req_signed_in, req_addr_in, req_wdata_in,
    input  mem_rd_in,
    output req_ready_out, rsp_valid_out, rsp_rdata_out, busy_out,
    output mem_addr_out, mem_we_out, mem_wd_out
  );

  modport master (
    output req_valid_in, req_we_in, req_size_in, req_signed_in, req_addr_in, req_wdata_in,
    output mem_rd_in,
    input  req_ready_out, rsp_valid_out, rsp_rdata_out, busy_out,
    input  mem_addr_out, mem_we_out, mem_wd_out
  );
endinterface

// File: rtl/mem8_access_sequencer.sv
// Byte/halfword/word load-store sequencer in front of an 8-bit data memory.
// Each request becomes 1, 2 or 4 single-byte memory cycles followed by a one-cycle completion pulse.
module mem8_access_sequencer #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input logic                    clk_in,
  input logic                    reset_in,
  mem8_access_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q;
  logic [1:0]        last_cnt;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [31:0]       asm_d;
  logic [31:0]       rdata_q;
  logic              ready_c;
  logic              accept;

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                               input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = raw[7:0];
    h = raw[15:0];
    case (size)
      2'b00:   if (sgn) ext = 32'(b); else ext = {24'd0, raw[7:0]};
      2'b01:   if (sgn) ext = 32'(h); else ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

  // Size 2'b11 runs as a word; lane order flips for big-endian memories.
  assign last_cnt = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;
  assign lane     = BIG_ENDIAN ? (last_cnt - cnt_q) : cnt_q;

  assign bus.req_ready_out = ready_c & ~reset_in;
  assign bus.busy_out      = ~bus.req_ready_out;
  assign bus.rsp_rdata_out = rdata_q;
  assign accept            = bus.req_valid_in & bus.req_ready_out;

  always_comb begin
    asm_d = asm_q;
    asm_d[{lane, 3'b000} +: 8] = bus.mem_rd_in;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    ready_c           = 1'b0;
    bus.rsp_valid_out = 1'b0;
    bus.mem_we_out    = 1'b0;
    bus.mem_addr_out  = '0;
    bus.mem_wd_out    = 8'd0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid_in) state_d = XFER;
      end
      XFER: begin
        bus.mem_addr_out = base_q + ADDR_W'(cnt_q);
        bus.mem_we_out   = we_q;
        if (we_q) bus.mem_wd_out = wdata_q[{lane, 3'b000} +: 8];
        if (cnt_q == last_cnt) state_d = DONE;
      end
      DONE: begin
        bus.rsp_valid_out = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The final byte of a load is folded in on the edge entering DONE, so the result is valid with the pulse.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q   <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      if (accept)                 cnt_q <= 2'd0;
      else if (state_q == XFER)   cnt_q <= cnt_q + 2'd1;
      if (state_q == XFER && !we_q && cnt_q == last_cnt)
        rdata_q <= extend_load(asm_d, size_q, signed_q);
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      base_q   <= bus.req_addr_in;
      we_q     <= bus.req_we_in;
      size_q   <= bus.req_size_in;
      signed_q <= bus.req_signed_in;
      wdata_q  <= bus.req_wdata_in;
    end
    if (state_q == XFER && !we_q) asm_q <= asm_d;
  end
endmodule

// File: tb/tb_mem8_access_sequencer.sv
// Directed bench: a little-endian and a big-endian sequencer share one request stream,
// each with its own 256-byte memory model (address bits [7:0]).
module tb_mem8_access_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        be_sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [7:0]  mem_le [256];
  logic [7:0]  mem_be [256];
  int          n_chk = 0;
  int          n_fail = 0;
  int          rsp_cnt = 0;

  logic        o_ready, o_rsp, o_we, o_busy;
  logic [31:0] o_rdata, o_addr;
  logic [7:0]  o_wd;

  mem8_access_sequencer_if #(.ADDR_W(32)) le_if ();
  mem8_access_sequencer_if #(.ADDR_W(32)) be_if ();

  mem8_access_sequencer #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
    .clk_in(clk), .reset_in(rst), .bus(le_if.slave));
  mem8_access_sequencer #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clk_in(clk), .reset_in(rst), .bus(be_if.slave));

  assign le_if.req_valid_in  = req_valid;
  assign le_if.req_we_in     = req_we;
  assign le_if.req_size_in   = req_size;
  assign le_if.req_signed_in = req_signed;
  assign le_if.req_addr_in   = req_addr;
  assign le_if.req_wdata_in  = req_wdata;
  assign le_if.mem_rd_in     = mem_le[le_if.mem_addr_out[7:0]];
  assign be_if.req_valid_in  = req_valid;
  assign be_if.req_we_in     = req_we;
  assign be_if.req_size_in   = req_size;
  assign be_if.req_signed_in = req_signed;
  assign be_if.req_addr_in   = req_addr;
  assign be_if.req_wdata_in  = req_wdata;
  assign be_if.mem_rd_in     = mem_be[be_if.mem_addr_out[7:0]];

  assign o_ready = be_sel ? be_if.req_ready_out : le_if.req_ready_out;
  assign o_rsp   = be_sel ? be_if.rsp_valid_out : le_if.rsp_valid_out;
  assign o_we    = be_sel ? be_if.mem_we_out    : le_if.mem_we_out;
  assign o_busy  = be_sel ? be_if.busy_out      : le_if.busy_out;
  assign o_rdata = be_sel ? be_if.rsp_rdata_out : le_if.rsp_rdata_out;
  assign o_addr  = be_sel ? be_if.mem_addr_out  : le_if.mem_addr_out;
  assign o_wd    = be_sel ? be_if.mem_wd_out    : le_if.mem_wd_out;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (le_if.mem_we_out) mem_le[le_if.mem_addr_out[7:0]] <= le_if.mem_wd_out;
    if (be_if.mem_we_out) mem_be[be_if.mem_addr_out[7:0]] <= be_if.mem_wd_out;
    if (o_rsp) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!o_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
  endtask

  // exp_bytes holds the byte expected at addr+i in bits [8i+7:8i].
  task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input int n,
                      input logic [31:0] exp_bytes, input logic [31:0] exp_rdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    wait_ready(tag);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~w; req_size = 2'b00; req_signed = ~sg;
    req_addr = ~a; req_wdata = ~wd;
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_addr"}, o_addr, a + 32'(i));
      check_eq({tag, "_we"}, {31'd0, o_we}, {31'd0, w});
      if (w) check_eq({tag, "_wd"}, {24'd0, o_wd}, {24'd0, exp_bytes[8*i +: 8]});
      check_eq({tag, "_busy"}, {30'd0, o_ready, o_rsp}, 32'd0);
      @(negedge clk);
    end
    check_eq({tag, "_done"}, {29'd0, o_rsp, o_ready, o_we}, 32'd4);
    check_eq({tag, "_rdata"}, o_rdata, exp_rdata);
    @(negedge clk);
    check_eq({tag, "_idle"}, {30'd0, o_rsp, o_ready}, 32'd1);
  endtask

  initial begin
    int rb;
    for (int i = 0; i < 256; i++) begin
      mem_le[i] = 8'h00;
      mem_be[i] = 8'h00;
    end
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", {28'd0, o_ready, o_rsp, o_we, o_busy}, 32'd1);
    check_eq("rst_rdata", o_rdata, 32'd0);
    check_eq("rst_addr", o_addr, 32'd0);
    check_eq("rst_wd", {24'd0, o_wd}, 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", {31'd0, o_ready}, 32'd1);

    xfer("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 4, 32'hDEADBEEF, 32'd0);
    check_eq("mem_st_w", {mem_le[8'h13], mem_le[8'h12], mem_le[8'h11], mem_le[8'h10]}, 32'hDEADBEEF);
    xfer("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 4, 32'd0, 32'hDEADBEEF);
    xfer("ld_sb", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 1, 32'd0, 32'hFFFFFFDE);
    xfer("ld_uh", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 2, 32'd0, 32'h0000DEAD);

    xfer("st_wrap", 1'b1, 2'b11, 1'b0, 32'hFFFFFFFE, 32'h11223344, 4, 32'h11223344, 32'h0000DEAD);
    check_eq("mem_wrap", {mem_le[8'h01], mem_le[8'h00], mem_le[8'hFF], mem_le[8'hFE]}, 32'h11223344);
    xfer("ld_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'd0, 4, 32'd0, 32'h11223344);

    // Abort a word store after two byte writes.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    wait_ready("abort");
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rb = rsp_cnt;
    rst = 1'b1;
    #1;
    check_eq("abort_async", {29'd0, o_ready, o_rsp, o_we}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_mem", {mem_le[8'h23], mem_le[8'h22], mem_le[8'h21], mem_le[8'h20]}, 32'h0000F00D);
    check_eq("abort_rsp", 32'(rsp_cnt - rb), 32'd0);
    check_eq("abort_rdata", o_rdata, 32'd0);
    check_eq("abort_ready", {31'd0, o_ready}, 32'd1);
    xfer("ld_after", 1'b0, 2'b00, 1'b0, 32'h20, 32'd0, 1, 32'd0, 32'h0000000D);

    // Back-to-back byte loads with valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h10;
    rb = rsp_cnt;
    check_eq("q_ready0", {31'd0, o_ready}, 32'd1);
    @(negedge clk);
    req_addr = 32'h13; req_signed = 1'b1;
    check_eq("q_xfer0", {30'd0, o_ready, o_rsp}, 32'd0);
    @(negedge clk);
    check_eq("q_done0", {30'd0, o_ready, o_rsp}, 32'd1);
    check_eq("q_rdata0", o_rdata, 32'h000000EF);
    @(negedge clk);
    check_eq("q_idle", {30'd0, o_ready, o_rsp}, 32'd2);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("q_xfer1", {30'd0, o_ready, o_rsp}, 32'd0);
    @(negedge clk);
    check_eq("q_done1", {30'd0, o_ready, o_rsp}, 32'd1);
    check_eq("q_rdata1", o_rdata, 32'hFFFFFFDE);
    @(negedge clk);
    check_eq("q_rsp_count", 32'(rsp_cnt - rb), 32'd2);

    // Big-endian instance; its last load result was signed byte 0xEF from 0x13.
    be_sel = 1'b1;
    xfer("be_st_h", 1'b1, 2'b01, 1'b0, 32'h40, 32'h0000A1B2, 2, 32'h0000B2A1, 32'hFFFFFFEF);
    check_eq("be_mem", {16'd0, mem_be[8'h41], mem_be[8'h40]}, 32'h0000B2A1);
    xfer("be_ld_sh", 1'b0, 2'b01, 1'b1, 32'h40, 32'd0, 2, 32'd0, 32'hFFFFA1B2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
